// File: rtl/parallel_io_responder.sv
// parallel_io_responder
//   I/O-mapped byte responder with a four-register window at BASE:
//     offset 0  RSR  status   (read)  {5'b0, OV, FO, FI}
//     offset 1  RBR  receive  (read)  last byte captured from the producer
//     offset 2  TBR  transmit (write) byte handed to the consumer
//     offset 3  reserved, reads 8'h00, writes ignored
//   Read side effects and write commits happen on the trailing (rising)
//   edge of the strobe, as seen at the first posedge sampling it high.
//
// Ports
//   clock     system clock, all state changes on posedge
//   reset_    synchronous active-low reset
//   addr      16-bit I/O address from the bus initiator
//   data      bidirectional data bus, driven only during a hit read
//   ior_/iow_ active-low read / write strobes
//   in_data, in_dav_, in_rfd     producer handshake (byte in)
//   out_data, out_dav_, out_rfd  consumer handshake (byte out)
//
// Configuration
//   OVERRUN_DETECT_EN  when defined, RSR bit 2 (OV) latches a TBR write that
//                      was dropped because the transmitter was busy; an RSR
//                      read clears it. When undefined, bit 2 reads 0.

module parallel_io_responder #(
  parameter logic [15:0] BASE = 16'h0100
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic [15:0] addr,
  inout  wire  [7:0]  data,
  input  logic        ior_,
  input  logic        iow_,
  input  logic [7:0]  in_data,
  input  logic        in_dav_,
  output logic        in_rfd,
  output logic [7:0]  out_data,
  output logic        out_dav_,
  input  logic        out_rfd
);

  typedef enum logic [1:0] {
    IN_IDLE = 2'd0,
    IN_CAPT = 2'd1,
    IN_FULL = 2'd2
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE = 2'd0,
    OUT_WAIT = 2'd1,
    OUT_DAV  = 2'd2,
    OUT_END  = 2'd3
  } out_state_t;

  // decode and strobe-edge signals
  logic       hit_s;
  logic [1:0] offset_s;
  logic       rd_commit_s;
  logic       wr_commit_s;
  logic       rbr_rd_s;
  logic       tbr_wr_s;
  logic       accept_s;
  logic       fi_set_s;
  logic       ov_s;
  logic [7:0] rd_mux_s;
  logic       rd_drive_s;

  // state
  logic       ior_d_r;
  logic       iow_d_r;
  logic [7:0] wr_latch_r;
  logic [7:0] rbr_r;
  logic       fi_r;
  logic       fo_r;
  logic       in_rfd_r;
  logic [7:0] out_data_r;
  logic       out_dav_r;
  in_state_t  in_state_r;
  out_state_t out_state_r;

  // Address decode, strobe trailing-edge detection and register events
  always_comb begin
    hit_s       = (addr[15:2] == BASE[15:2]);
    offset_s    = addr[1:0];
    rd_commit_s = ior_ & ~ior_d_r;
    wr_commit_s = iow_ & ~iow_d_r;
    rbr_rd_s    = rd_commit_s & hit_s & (offset_s == 2'd1);
    tbr_wr_s    = wr_commit_s & hit_s & (offset_s == 2'd2);
    // FO doubles as the "transmitter accepts" flag, so a write landing in
    // OUT_END (FO already back to 1) starts the next transfer directly.
    accept_s    = tbr_wr_s & fo_r;
    fi_set_s    = (in_state_r == IN_IDLE) & ~in_dav_ & ~fi_r;
  end

  // Strobe history and write-data latch (tracks the bus while iow_ is low)
  always_ff @(posedge clock) begin
    if (!reset_) begin
      ior_d_r    <= 1'b1;
      iow_d_r    <= 1'b1;
      wr_latch_r <= 8'h00;
    end else begin
      ior_d_r <= ior_;
      iow_d_r <= iow_;
      if (!iow_) begin
        wr_latch_r <= data;
      end
    end
  end

  // Producer-side handshake FSM, receive buffer and FI flag
  always_ff @(posedge clock) begin
    if (!reset_) begin
      in_state_r <= IN_IDLE;
      in_rfd_r   <= 1'b0;
      rbr_r      <= 8'h00;
      fi_r       <= 1'b0;
    end else begin
      case (in_state_r)
        IN_IDLE: begin
          if (fi_set_s) begin
            in_state_r <= IN_CAPT;
            rbr_r      <= in_data;
            in_rfd_r   <= 1'b0;
          end else begin
            in_rfd_r <= ~fi_r;
          end
        end
        IN_CAPT: begin
          in_rfd_r <= 1'b0;
          if (in_dav_) begin
            in_state_r <= IN_FULL;
          end
        end
        IN_FULL: begin
          // Ready is re-offered only once the host has drained RBR.
          if (!fi_r) begin
            in_state_r <= IN_IDLE;
            in_rfd_r   <= 1'b1;
          end else begin
            in_rfd_r <= 1'b0;
          end
        end
        default: begin
          in_state_r <= IN_IDLE;
          in_rfd_r   <= 1'b0;
        end
      endcase
      // a capture outranks a same-cycle RBR read commit
      if (fi_set_s) begin
        fi_r <= 1'b1;
      end else if (rbr_rd_s) begin
        fi_r <= 1'b0;
      end
    end
  end

  // Consumer-side handshake FSM, transmit byte and FO flag
  always_ff @(posedge clock) begin
    if (!reset_) begin
      out_state_r <= OUT_IDLE;
      out_data_r  <= 8'h00;
      out_dav_r   <= 1'b1;
      fo_r        <= 1'b1;
    end else begin
      case (out_state_r)
        OUT_IDLE: begin
          out_dav_r <= 1'b1;
          if (accept_s) begin
            out_data_r  <= wr_latch_r;
            fo_r        <= 1'b0;
            out_state_r <= OUT_WAIT;
          end else begin
            fo_r <= 1'b1;
          end
        end
        OUT_WAIT: begin
          // out_data already settled one edge earlier, giving setup to dav
          if (out_rfd) begin
            out_state_r <= OUT_DAV;
            out_dav_r   <= 1'b0;
          end
        end
        OUT_DAV: begin
          if (!out_rfd) begin
            out_state_r <= OUT_END;
            out_dav_r   <= 1'b1;
            fo_r        <= 1'b1;
          end
        end
        OUT_END: begin
          out_dav_r <= 1'b1;
          if (accept_s) begin
            out_data_r  <= wr_latch_r;
            fo_r        <= 1'b0;
            out_state_r <= OUT_WAIT;
          end else begin
            out_state_r <= OUT_IDLE;
          end
        end
        default: begin
          out_state_r <= OUT_IDLE;
          out_dav_r   <= 1'b1;
          fo_r        <= 1'b1;
        end
      endcase
    end
  end

`ifdef OVERRUN_DETECT_EN
  logic discard_s;
  logic rsr_rd_s;
  logic ov_r;

  // Overrun event decode: dropped TBR write, RSR read commit
  always_comb begin
    discard_s = tbr_wr_s & ~fo_r;
    rsr_rd_s  = rd_commit_s & hit_s & (offset_s == 2'd0);
  end

  // Overrun flag; a new overrun outranks a same-cycle RSR read clear
  always_ff @(posedge clock) begin
    if (!reset_) begin
      ov_r <= 1'b0;
    end else if (discard_s) begin
      ov_r <= 1'b1;
    end else if (rsr_rd_s) begin
      ov_r <= 1'b0;
    end
  end

  assign ov_s = ov_r;
`else
  assign ov_s = 1'b0;
`endif

  // Read data selection by window offset
  always_comb begin
    rd_mux_s = 8'h00;
    case (offset_s)
      2'd0:    rd_mux_s = {5'b00000, ov_s, fo_r, fi_r};
      2'd1:    rd_mux_s = rbr_r;
      default: rd_mux_s = 8'h00;
    endcase
  end

  assign rd_drive_s = hit_s & ~ior_;
  assign data       = rd_drive_s ? rd_mux_s : 8'hzz;

  assign in_rfd   = in_rfd_r;
  assign out_data = out_data_r;
  assign out_dav_ = out_dav_r;

endmodule

// File: tb/tb_parallel_io_responder.sv
`timescale 1ns/1ps
module tb_parallel_io_responder;

  logic        clock = 1'b0;
  logic        reset_;
  logic [15:0] addr;
  wire  [7:0]  data;
  logic        ior_;
  logic        iow_;
  logic [7:0]  in_data;
  logic        in_dav_;
  logic        in_rfd;
  logic [7:0]  out_data;
  logic        out_dav_;
  logic        out_rfd;

  logic        tb_drive;
  logic [7:0]  tb_data;
  assign data = tb_drive ? tb_data : 8'hzz;

  int total = 0;
  int bad   = 0;

`ifdef OVERRUN_DETECT_EN
  localparam logic OV_EN = 1'b1;
`else
  localparam logic OV_EN = 1'b0;
`endif

  // reference model: flags and bytes as the host would see them
  logic       m_fi;
  logic       m_fo;
  logic       m_ov;
  logic [7:0] m_rbr;
  logic [7:0] m_out;

  always #5 clock = ~clock;

  parallel_io_responder #(.BASE(16'h0100)) dut (
    .clock    (clock),
    .reset_   (reset_),
    .addr     (addr),
    .data     (data),
    .ior_     (ior_),
    .iow_     (iow_),
    .in_data  (in_data),
    .in_dav_  (in_dav_),
    .in_rfd   (in_rfd),
    .out_data (out_data),
    .out_dav_ (out_dav_),
    .out_rfd  (out_rfd)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m_rsr();
    return {5'b00000, (OV_EN & m_ov), m_fo, m_fi};
  endfunction

  task automatic model_reset();
    m_fi  = 1'b0;
    m_fo  = 1'b1;
    m_ov  = 1'b0;
    m_rbr = 8'h00;
    m_out = 8'h00;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] v);
    tb_drive = 1'b0;
    addr     = a;
    ior_     = 1'b0;
    tick();
    v    = data;
    ior_ = 1'b1;
    tick();
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] v);
    tb_drive = 1'b1;
    tb_data  = v;
    addr     = a;
    iow_     = 1'b0;
    tick();
    iow_ = 1'b1;
    tick();
    tb_drive = 1'b0;
  endtask

  task automatic read_rsr(input string tag);
    logic [7:0] exp;
    logic [7:0] v;
    exp = m_rsr();
    bus_read(16'h0100, v);
    chk(tag, v, exp);
    m_ov = 1'b0;
  endtask

  task automatic read_rbr(input string tag);
    logic [7:0] v;
    bus_read(16'h0101, v);
    chk(tag, v, m_rbr);
    m_fi = 1'b0;
    tick();
  endtask

  task automatic write_tbr(input logic [7:0] v);
    bus_write(16'h0102, v);
    if (m_fo) begin
      m_out = v;
      m_fo  = 1'b0;
    end else begin
      m_ov = OV_EN;
    end
  endtask

  task automatic produce(input string tag, input logic [7:0] v);
    for (int i = 0; i < 20 && !in_rfd; i++) tick();
    chk({tag, "_rfd_wait"}, {7'd0, in_rfd}, 8'd1);
    in_data = v;
    in_dav_ = 1'b0;
    tick();
    in_dav_ = 1'b1;
    tick();
    m_rbr = v;
    m_fi  = 1'b1;
  endtask

  task automatic consume(input string tag);
    out_rfd = 1'b1;
    for (int i = 0; i < 20 && out_dav_; i++) tick();
    chk({tag, "_dav_low"}, {7'd0, out_dav_}, 8'd0);
    chk({tag, "_data"}, out_data, m_out);
    out_rfd = 1'b0;
    for (int i = 0; i < 20 && !out_dav_; i++) tick();
    chk({tag, "_dav_high"}, {7'd0, out_dav_}, 8'd1);
    m_fo = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_dav"}, {7'd0, out_dav_}, 8'd1);
    chk({tag, "_out_data"}, out_data, m_out);
    chk({tag, "_rfd"}, {7'd0, in_rfd}, {7'd0, ~m_fi});
  endtask

  initial begin
    logic [7:0] v;
    int op;

    reset_   = 1'b0;
    addr     = 16'h0000;
    ior_     = 1'b1;
    iow_     = 1'b1;
    in_data  = 8'h00;
    in_dav_  = 1'b1;
    out_rfd  = 1'b0;
    tb_drive = 1'b0;
    tb_data  = 8'h00;
    model_reset();

    // reset state
    tick(); tick(); tick();
    chk("rst_in_rfd", {7'd0, in_rfd}, 8'd0);
    chk("rst_out_dav", {7'd0, out_dav_}, 8'd1);
    chk("rst_out_data", out_data, 8'h00);
    reset_ = 1'b1;
    tick();
    chk("post_rst_in_rfd", {7'd0, in_rfd}, 8'd1);

    // status, reserved offset, non-hit read leaves the bus alone
    bus_read(16'h0100, v);
    chk("rsr_after_reset", v, 8'h02);
    bus_read(16'h0103, v);
    chk("reserved_read", v, 8'h00);
    tb_drive = 1'b1;
    tb_data  = 8'hA5;
    addr     = 16'h0200;
    ior_     = 1'b0;
    tick();
    chk("nohit_read_bus", data, 8'hA5);
    ior_ = 1'b1;
    tick();
    tb_drive = 1'b0;

    // producer byte into RBR
    produce("p5a", 8'h5A);
    chk("p5a_rfd_low", {7'd0, in_rfd}, 8'd0);
    bus_read(16'h0100, v);
    chk("p5a_rsr", v, 8'h03);
    read_rbr("p5a_rbr");
    chk("p5a_rbr_value_seen", m_rbr, 8'h5A);
    bus_read(16'h0100, v);
    chk("p5a_rsr_after", v, 8'h02);
    chk("p5a_rfd_back", {7'd0, in_rfd}, 8'd1);

    // stale RBR read with FI clear
    bus_read(16'h0101, v);
    chk("stale_rbr", v, 8'h5A);
    bus_read(16'h0100, v);
    chk("stale_rsr", v, 8'h02);

    // one transmit transfer
    write_tbr(8'hC3);
    chk("c3_out_data", out_data, 8'hC3);
    chk("c3_dav_idle", {7'd0, out_dav_}, 8'd1);
    read_rsr("c3_rsr_busy");
    consume("c3");
    bus_read(16'h0100, v);
    chk("c3_rsr_free", v, 8'h02);

    // overrun: second write while busy is dropped
    write_tbr(8'h11);
    write_tbr(8'h22);
    chk("ovr_out_data", out_data, 8'h11);
    bus_read(16'h0100, v);
    chk("ovr_rsr", v, OV_EN ? 8'h04 : 8'h00);
    m_ov = 1'b0;
    bus_read(16'h0100, v);
    chk("ovr_rsr_cleared", v, 8'h00);
    consume("ovr");
    chk("ovr_delivered", out_data, 8'h11);

    // writes to non-TBR offsets and outside the window have no effect
    bus_write(16'h0100, 8'h77);
    bus_write(16'h0101, 8'h78);
    bus_write(16'h0103, 8'h79);
    bus_write(16'h0202, 8'h7A);
    chk("ignored_writes_data", out_data, 8'h11);
    read_rsr("ignored_writes_rsr");

    // randomized traffic against the model
    for (int n = 0; n < 80; n++) begin
      op = $urandom_range(0, 5);
      case (op)
        0: if (!m_fi) produce("rnd_prod", 8'($urandom_range(0, 255)));
        1: read_rsr("rnd_rsr");
        2: read_rbr("rnd_rbr");
        3: write_tbr(8'($urandom_range(0, 255)));
        4: if (!m_fo) consume("rnd_cons"); else tick();
        default: begin
          bus_read(16'h0103, v);
          chk("rnd_reserved", v, 8'h00);
        end
      endcase
      check_idle("rnd_idle");
    end
    if (!m_fo) consume("rnd_drain");
    if (m_fi) read_rbr("rnd_drain_rbr");

    // reset in the middle of both handshakes
    produce("mid", 8'h3C);
    write_tbr(8'h96);
    out_rfd = 1'b1;
    for (int i = 0; i < 20 && out_dav_; i++) tick();
    chk("mid_dav_low", {7'd0, out_dav_}, 8'd0);
    reset_ = 1'b0;
    tick();
    chk("mid_rst_dav", {7'd0, out_dav_}, 8'd1);
    chk("mid_rst_out_data", out_data, 8'h00);
    chk("mid_rst_in_rfd", {7'd0, in_rfd}, 8'd0);
    reset_  = 1'b1;
    out_rfd = 1'b0;
    model_reset();
    tick();
    chk("mid_post_rfd", {7'd0, in_rfd}, 8'd1);
    bus_read(16'h0100, v);
    chk("mid_post_rsr", v, 8'h02);
    bus_read(16'h0101, v);
    chk("mid_post_rbr", v, 8'h00);
    check_idle("mid_post_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/parallel_io_responder.md
PARALLEL_IO_RESPONDER -- requirements
Module: parallel_io_responder

Interface
REQ-001 The block SHALL have parameter BASE, default 16'h0100, 16-bit I/O base address of the responder window (offsets 0..3).
REQ-002 The block SHALL have port clock  input  1  the single system clock; all state changes on posedge clock.
REQ-003 The block SHALL have port reset_  input  1  reset, synchronous and active-low.
REQ-004 The block SHALL have port addr  input  16  I/O address from bus initiator.
REQ-005 The block SHALL have port data  inout  8  bidirectional I/O data bus; high-Z unless driving a read.
REQ-006 The block SHALL have port ior_  input  1  active-low read strobe.
REQ-007 The block SHALL have port iow_  input  1  active-low write strobe.
REQ-008 The block SHALL have port in_data  input  8  byte from external producer.
REQ-009 The block SHALL have port in_dav_  input  1  producer data-valid, active-low.
REQ-010 The block SHALL have port in_rfd  output  1  ready-for-data to producer.
REQ-011 The block SHALL have port out_data  output  8  byte to external consumer.
REQ-012 The block SHALL have port out_dav_  output  1  data-valid to consumer, active-low.
REQ-013 The block SHALL have port out_rfd  input  1  consumer ready-for-data.

Function
REQ-014 Hit SHALL be addr[15:2]==BASE[15:2]; offset = addr[1:0]: 0 RSR status (read), 1 RBR receive buffer (read), 2 TBR transmit buffer (write), 3 reserved.
REQ-015 RSR SHALL read {5'b0, OV, FO, FI}: FI = receive byte pending, FO = transmitter free, OV per REQ-029.
REQ-016 Read: data SHALL be driven combinationally while ior_==0 and hit; offset 3 reads 8'h00; no hit or ior_==1 leaves data high-Z.
REQ-017 Read side effect (RBR read clears FI) SHALL occur at the first posedge where ior_ samples 1 after sampling 0, with offset 1 hit in that cycle.
REQ-018 Write: data SHALL be captured into an internal latch every posedge that samples iow_==0; the write commits at the first posedge sampling iow_==1 after 0, using addr of that cycle and the latched byte.
REQ-019 Writes to offsets 0,1,3 and non-hit writes SHALL have no effect.
REQ-020 Input FSM states: IN_IDLE (in_rfd=1) -> IN_CAPT when in_dav_ samples 0, loading RBR<=in_data and setting FI.
REQ-021 IN_CAPT (in_rfd=0) -> IN_FULL when in_dav_ samples 1.
REQ-022 IN_FULL (in_rfd=0) -> IN_IDLE in the cycle after FI clears; in_rfd never asserts while FI==1.
REQ-023 Output FSM states: OUT_IDLE (FO=1, out_dav_=1) -> OUT_WAIT on committed TBR write: out_data<=byte, FO<=0.
REQ-024 OUT_WAIT -> OUT_DAV when out_rfd samples 1; out_dav_<=0 one cycle later than out_data change minimum (setup).
REQ-025 OUT_DAV (out_dav_=0) -> OUT_END when out_rfd samples 0; OUT_END drives out_dav_=1, FO=1, -> OUT_IDLE.
REQ-026 TBR write while FO==0 SHALL be discarded; out_data stays stable for the whole transfer.
REQ-027 RBR read while FI==0 SHALL return stale RBR and have no side effect.
REQ-028 Simultaneous FI-set and RBR-read-commit in one cycle cannot occur (FI set only from IN_IDLE with FI==0); set wins if encountered.

Configuration
REQ-029 Macro OVERRUN_DETECT_EN defined: OV SET by a discarded TBR write (REQ-026), cleared by RSR read commit (as REQ-017, offset 0); set wins over clear same cycle.
REQ-030 Macro OVERRUN_DETECT_EN undefined: no OV flop; RSR bit2 reads 0.

Reset
REQ-031 On posedge clock with reset_==0: both FSMs to IDLE, FI=0, FO=1, OV=0, RBR=8'h00, out_data=8'h00, out_dav_=1, in_rfd=0 during reset then 1 first cycle after, data high-Z.
REQ-032 Reset mid-transfer SHALL abort either handshake immediately (out_dav_=1) with no byte delivered or retained.

Verification
REQ-033 Reset, read 0x0100 -> 8'h02; read 0x0103 -> 8'h00; read 0x0200 -> data high-Z.
REQ-034 Producer in_data=8'h5A, in_dav_ pulse -> in_rfd low, RSR=8'h03; read 0x0101 -> 8'h5A, then RSR=8'h02, in_rfd back to 1.
REQ-035 Write 8'hC3 to 0x0102, out_rfd=1 -> out_data=8'hC3, out_dav_ low; drop out_rfd -> out_dav_ high, FO=1.
REQ-036 Write 8'h11 then 8'h22 to 0x0102 with out_rfd=0 -> out_data stays 8'h11; with OVERRUN_DETECT_EN RSR=8'h04, next RSR read 8'h00.
REQ-037 Assert reset_=0 during OUT_DAV and IN_FULL -> next cycle out_dav_=1, FI=0, FO=1, RSR=8'h02.
